// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: two-requester register-file write arbiter with holding buffers and RAW scoreboard; optional forwarding via RF_WRITE_BYPASS_EN
module rf_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_WIDTH-1:0] a_rd,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_WIDTH-1:0] b_rd,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_data_in,
  output logic                  rf_src
`ifdef RF_WRITE_BYPASS_EN
  ,
  output logic [DATA_WIDTH-1:0] rs1_fwd_data,
  output logic [DATA_WIDTH-1:0] rs2_fwd_data
`endif
);
  logic                  ha, hb;
  logic [ADDR_WIDTH-1:0] ha_rd, hb_rd;
  logic [DATA_WIDTH-1:0] ha_data, hb_data;
  logic                  rr, age_v, age_b;
  logic                  a_load, b_load, grant_a, grant_b, tie, ha_n, hb_n;
  logic                  m1h, m1o, m2h, m2o, nz1, nz2;

  assign a_ready = !ha;
  assign b_ready = !hb;

  // arbitration: single holder wins, otherwise older entry, otherwise rr side
  always_comb begin
    a_load  = a_valid && !ha && a_rd != '0;
    b_load  = b_valid && !hb && b_rd != '0;
    tie     = ha && hb && !age_v;
    grant_a = ha && (!hb || (age_v ? !age_b : !rr));
    grant_b = hb && !grant_a;
    ha_n    = ha ? !grant_a : a_load;
    hb_n    = hb ? !grant_b : b_load;
  end

  // holding buffers, age/rr tracking and registered write port
  always_ff @(posedge clk) begin
    if (!reset) begin
      ha         <= 1'b0;
      hb         <= 1'b0;
      ha_rd      <= '0;
      hb_rd      <= '0;
      ha_data    <= '0;
      hb_data    <= '0;
      rr         <= 1'b0;
      age_v      <= 1'b0;
      age_b      <= 1'b0;
      rf_we      <= 1'b0;
      rf_rd      <= '0;
      rf_data_in <= '0;
      rf_src     <= 1'b0;
    end else begin
      ha    <= ha_n;
      hb    <= hb_n;
      age_v <= ha_n && hb_n && !(a_load && b_load);
      age_b <= (a_load && !b_load) ? 1'b1 : (b_load && !a_load) ? 1'b0 : age_b;
      rf_we <= grant_a || grant_b;
      if (a_load) begin
        ha_rd   <= a_rd;
        ha_data <= a_data;
      end
      if (b_load) begin
        hb_rd   <= b_rd;
        hb_data <= b_data;
      end
      if (tie) rr <= !rr;
      if (grant_a || grant_b) begin
        rf_rd      <= grant_b ? hb_rd : ha_rd;
        rf_data_in <= grant_b ? hb_data : ha_data;
        rf_src     <= grant_b;
      end
    end
  end

  // pending-write scoreboard; a buffered write is always newer than the one in the output stage
  always_comb begin
    nz1 = rs1 != '0;
    nz2 = rs2 != '0;
    m1h = (ha && ha_rd == rs1) || (hb && hb_rd == rs1);
    m2h = (ha && ha_rd == rs2) || (hb && hb_rd == rs2);
    m1o = rf_we && rf_rd == rs1;
    m2o = rf_we && rf_rd == rs2;
`ifdef RF_WRITE_BYPASS_EN
    rs1_busy     = nz1 && m1h;
    rs2_busy     = nz2 && m2h;
    rs1_fwd_data = (nz1 && !m1h && m1o) ? rf_data_in : '0;
    rs2_fwd_data = (nz2 && !m2h && m2o) ? rf_data_in : '0;
`else
    rs1_busy = nz1 && (m1h || m1o);
    rs2_busy = nz2 && (m2h || m2o);
`endif
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed stimulus checked every cycle against a timestamp-ordered behavioural model
module tb_rf_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  logic          clk = 0;
  logic          reset;
  logic          a_valid, b_valid;
  logic [AW-1:0] a_rd, b_rd, rs1, rs2;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready, rs1_busy, rs2_busy, rf_we, rf_src;
  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_data_in;
`ifdef RF_WRITE_BYPASS_EN
  logic [DW-1:0] rs1_fwd_data, rs2_fwd_data;
`endif

  rf_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_data_in(rf_data_in), .rf_src(rf_src)
`ifdef RF_WRITE_BYPASS_EN
    , .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // model: pending entries carry an arrival time; oldest wins, equal times go to rr
  logic          ma_v, mb_v, mrr, mout_we, mout_src;
  logic [AW-1:0] ma_rd, mb_rd, mout_rd;
  logic [DW-1:0] ma_data, mb_data, mout_data;
  int            ma_t, mb_t, tick;
  logic [DW-1:0] mrf [32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic oa, ob, ga, gb;
    oa = ma_v;
    ob = mb_v;
    if (mout_we) mrf[mout_rd] = mout_data;
    if (!reset) begin
      ma_v = 0; mb_v = 0; mrr = 0;
      mout_we = 0; mout_rd = 0; mout_data = 0; mout_src = 0;
    end else begin
      if (ma_v && mb_v) begin
        if (ma_t == mb_t) begin
          ga = !mrr;
          mrr = !mrr;
        end else ga = ma_t < mb_t;
      end else ga = ma_v;
      gb = mb_v && !ga;
      mout_we = ga || gb;
      if (ga) begin mout_rd = ma_rd; mout_data = ma_data; mout_src = 0; ma_v = 0; end
      if (gb) begin mout_rd = mb_rd; mout_data = mb_data; mout_src = 1; mb_v = 0; end
      if (!oa && a_valid && a_rd != 0) begin ma_v = 1; ma_rd = a_rd; ma_data = a_data; ma_t = tick; end
      if (!ob && b_valid && b_rd != 0) begin mb_v = 1; mb_rd = b_rd; mb_data = b_data; mb_t = tick; end
    end
    tick++;
  endtask

  function automatic logic held(input logic [AW-1:0] rs);
    return rs != 0 && ((ma_v && ma_rd == rs) || (mb_v && mb_rd == rs));
  endfunction

  function automatic logic in_out(input logic [AW-1:0] rs);
    return rs != 0 && mout_we && mout_rd == rs;
  endfunction

  task automatic compare_all();
    check("a_ready", a_ready, !ma_v);
    check("b_ready", b_ready, !mb_v);
    check("rf_we", rf_we, mout_we);
    check("rf_rd", rf_rd, mout_rd);
    check("rf_data_in", rf_data_in, mout_data);
    if (mout_we) check("rf_src", rf_src, mout_src);
`ifdef RF_WRITE_BYPASS_EN
    check("rs1_busy", rs1_busy, held(rs1));
    check("rs2_busy", rs2_busy, held(rs2));
    check("rs1_fwd", rs1_fwd_data, (!held(rs1) && in_out(rs1)) ? mout_data : 0);
    check("rs2_fwd", rs2_fwd_data, (!held(rs2) && in_out(rs2)) ? mout_data : 0);
`else
    check("rs1_busy", rs1_busy, held(rs1) || in_out(rs1));
    check("rs2_busy", rs2_busy, held(rs2) || in_out(rs2));
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mrf[i] = 0;
    ma_v = 0; mb_v = 0; mrr = 0; mout_we = 0; mout_src = 0;
    ma_rd = 0; mb_rd = 0; mout_rd = 0; ma_data = 0; mb_data = 0; mout_data = 0;
    ma_t = 0; mb_t = 0; tick = 0;
    reset = 0; a_valid = 1; a_rd = 9; a_data = 32'h99; b_valid = 0; b_rd = 0; b_data = 0;
    rs1 = 0; rs2 = 0;
    cycle(); cycle();
    check("reset_a_ready", a_ready, 1);
    check("reset_b_ready", b_ready, 1);
    check("reset_rf_we", rf_we, 0);
    reset = 1; a_rd = 3; a_data = 16;
    cycle();
    a_valid = 0;
    cycle();
    check("t1_we", rf_we, 1);
    check("t1_rd", rf_rd, 3);
    check("t1_data", rf_data_in, 16);
    cycle();
    check("t1_x3", mrf[3], 16);
    check("t1_x9_untouched", mrf[9], 0);
    for (int r = 0; r < 2; r++) begin
      a_valid = 1; a_rd = 2; a_data = 8; b_valid = 1; b_rd = 5; b_data = 32'hDEADBEEF;
      cycle();
      a_valid = 0; b_valid = 0;
      cycle();
      check("t2_first_src", rf_src, r[0]);
      cycle();
      check("t2_second_src", rf_src, !r[0]);
      check("t2_second_data", rf_data_in, r[0] ? 8 : 32'hDEADBEEF);
      cycle();
    end
    b_valid = 1; b_rd = 7; b_data = 1;
    cycle();
    b_valid = 0; a_valid = 1; a_rd = 7; a_data = 2;
    cycle();
    check("t3_b_first", rf_data_in, 1);
    a_valid = 0;
    cycle();
    check("t3_a_second", rf_data_in, 2);
    cycle();
    check("t3_x7", mrf[7], 2);
    a_valid = 1; a_rd = 0; a_data = 32'h55;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t4_ready", a_ready, 1);
      check("t4_no_we", rf_we, 0);
      check("t4_rs1_zero", rs1_busy, 0);
    end
    a_valid = 1; a_rd = 4; a_data = 32'h44; rs1 = 4; rs2 = 4;
    cycle();
    a_valid = 0;
    check("t5_busy_hold", rs1_busy, 1);
    cycle();
`ifdef RF_WRITE_BYPASS_EN
    check("t5_busy_out", rs2_busy, 0);
    check("t5_fwd", rs1_fwd_data, 32'h44);
`else
    check("t5_busy_out", rs2_busy, 1);
`endif
    cycle();
    check("t5_busy_done", rs1_busy, 0);
    for (int i = 0; i < 12; i++) begin
      a_valid = (i % 4) != 3; a_rd = AW'(1 + i % 3); a_data = 32'h1000 + i;
      b_valid = 1; b_rd = AW'(2 + i % 5); b_data = 32'h2000 + i;
      rs1 = AW'(i % 8); rs2 = AW'(2 + i % 4);
      cycle();
    end
    a_valid = 1; a_rd = 12; a_data = 32'hAA; b_valid = 1; b_rd = 13; b_data = 32'hBB;
    cycle(); cycle();
    a_valid = 0; b_valid = 0;
    cycle();
    a_valid = 1; a_rd = 12; a_data = 32'hAC; b_valid = 1; b_rd = 13; b_data = 32'hBC;
    cycle();
    a_valid = 0; b_valid = 0; reset = 0; rs1 = 12; rs2 = 13;
    cycle();
    check("t6_we", rf_we, 0);
    check("t6_a_ready", a_ready, 1);
    check("t6_busy", rs2_busy, 0);
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t6_no_write", rf_we, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
